// File: rtl/axist_param_patgen_if.sv
// rtl/axist_param_patgen_if.sv - output stream bundle of the parameterised pattern generator
interface axist_param_patgen_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0]   axist_tdata;
    logic                    axist_tvalid;
    logic                    axist_tlast;
    logic [DATA_WIDTH/8-1:0] axist_tkeep;
    logic                    axist_rdy;

    modport master (
        output axist_tdata, axist_tvalid, axist_tlast, axist_tkeep,
        input  axist_rdy
    );

    modport slave (
        input  axist_tdata, axist_tvalid, axist_tlast, axist_tkeep,
        output axist_rdy
    );
endinterface

// File: rtl/axist_param_patgen.sv
// rtl/axist_param_patgen.sv - stream pattern generator (fixed/PRBS32/incr/walking-one) with show-ahead output buffer
module axist_param_patgen #(
    parameter int          DATA_WIDTH = 256,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] PRBS_SEED  = 32'hFFAA_5555,
    parameter logic [31:0] INCR_SEED  = 32'h0000_0000
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  patgen_en,
    input  logic [1:0]            patgen_sel,
    input  logic                  cntuspatt_en,
    input  logic [CNT_WIDTH-1:0]  patgen_cnt,
    input  logic [7:0]            pkt_len,
    input  logic                  chkr_fifo_full,
    axist_param_patgen_if.master  axist,
    output logic [DATA_WIDTH-1:0] patgen_exp_dout,
    output logic                  patgen_exp_valid,
    output logic                  patgen_busy,
    output logic                  patgen_done,
    output logic [31:0]           beat_cnt
);
    localparam int          NUM_LANES  = DATA_WIDTH / 32;
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LFSR_SEED  = (PRBS_SEED == 32'h0) ? 32'h1 : PRBS_SEED;
    localparam logic [31:0] FIXED_WORD = 32'h1111_2222;
    // x^32 + x^22 + x^2 + x + 1 taps bits 31, 21, 1 and 0 of the left-shifting register
    localparam logic [31:0] PRBS_TAPS  = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                state;
    logic                  en_q;
    logic [1:0]            sel_r;
    logic                  cont_r;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [7:0]            pkt_len_r;
    logic [7:0]            pkt_cnt;
    logic [31:0]           gen_word;
    logic [31:0]           next_word;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  push_last;
    logic                  last_of_run;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH:0]   head;

    function automatic logic [31:0] seed_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return FIXED_WORD;
            2'b01:   return LFSR_SEED;
            2'b10:   return INCR_SEED;
            default: return 32'h0000_0001;
        endcase
    endfunction

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign last_of_run = !cont_r && (remaining == CNT_WIDTH'(1));
    assign push        = (state == S_RUN) && patgen_en && !fifo_full && !chkr_fifo_full
                         && (cont_r || (remaining != '0));
    assign pop         = !fifo_empty && axist.axist_rdy;
    assign push_last   = (pkt_cnt == (pkt_len_r - 8'd1)) || last_of_run;

    // Next generator word for the latched pattern; only taken on a push
    always_comb begin
        next_word = gen_word;
        case (sel_r)
            2'b00:   next_word = gen_word;
            2'b01:   next_word = {gen_word[30:0], ^(gen_word & PRBS_TAPS)};
            2'b10:   next_word = gen_word + 32'd1;
            default: next_word = {gen_word[30:0], gen_word[31]};
        endcase
    end

    // Spread the generator word over all lanes with a per-lane XOR signature
    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            push_data[i*32 +: 32] = gen_word ^ (32'(i) * 32'h0101_0101);
        end
    end

    assign head                = mem[rd_ptr[AW-1:0]];
    assign axist.axist_tvalid  = !fifo_empty;
    assign axist.axist_tdata   = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign axist.axist_tlast   = fifo_empty ? 1'b0 : head[DATA_WIDTH];
    assign axist.axist_tkeep   = '1;
    assign patgen_exp_valid    = push;
    assign patgen_exp_dout     = push ? push_data : '0;
    assign patgen_busy         = (state != S_IDLE);

    // Buffer storage; contents are don't-care while the pointers say empty
    always_ff @(posedge wr_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
        end
    end

    // Buffer pointers; a reset empties the buffer and discards queued beats
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Run control: start edge detect, generator, counters and done pulse
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            en_q        <= 1'b0;
            sel_r       <= 2'b00;
            cont_r      <= 1'b0;
            remaining   <= '0;
            pkt_len_r   <= 8'd1;
            pkt_cnt     <= 8'd0;
            gen_word    <= LFSR_SEED;
            patgen_done <= 1'b0;
            beat_cnt    <= 32'd0;
        end else begin
            en_q        <= patgen_en;
            patgen_done <= 1'b0;
            if (pop && (beat_cnt != 32'hFFFF_FFFF)) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (patgen_en && !en_q) begin
                        sel_r     <= patgen_sel;
                        cont_r    <= cntuspatt_en;
                        remaining <= patgen_cnt;
                        pkt_len_r <= (pkt_len == 8'd0) ? 8'd1 : pkt_len;
                        pkt_cnt   <= 8'd0;
                        gen_word  <= seed_of(patgen_sel);
                        beat_cnt  <= 32'd0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        gen_word <= next_word;
                        pkt_cnt  <= push_last ? 8'd0 : pkt_cnt + 8'd1;
                        if (!cont_r) remaining <= remaining - CNT_WIDTH'(1);
                    end
                    if (!patgen_en || (!cont_r && ((remaining == '0) || (push && last_of_run)))) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    if (fifo_empty) begin
                        patgen_done <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axist_param_patgen.sv
// tb/tb_axist_param_patgen.sv - self-checking bench for axist_param_patgen
module tb_axist_param_patgen;
    localparam int DW = 64;
    localparam int NL = DW / 32;
    localparam int FD = 4;

    logic          wr_clk = 1'b0;
    logic          rst_n;
    logic          patgen_en;
    logic [1:0]    patgen_sel;
    logic          cntuspatt_en;
    logic [15:0]   patgen_cnt;
    logic [7:0]    pkt_len;
    logic          chkr_fifo_full;
    logic [DW-1:0] patgen_exp_dout;
    logic          patgen_exp_valid;
    logic          patgen_busy;
    logic          patgen_done;
    logic [31:0]   beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    axist_param_patgen_if #(.DATA_WIDTH(DW)) axi ();

    axist_param_patgen #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .wr_clk           (wr_clk),
        .rst_n            (rst_n),
        .patgen_en        (patgen_en),
        .patgen_sel       (patgen_sel),
        .cntuspatt_en     (cntuspatt_en),
        .patgen_cnt       (patgen_cnt),
        .pkt_len          (pkt_len),
        .chkr_fifo_full   (chkr_fifo_full),
        .axist            (axi.master),
        .patgen_exp_dout  (patgen_exp_dout),
        .patgen_exp_valid (patgen_exp_valid),
        .patgen_busy      (patgen_busy),
        .patgen_done      (patgen_done),
        .beat_cnt         (beat_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [1:0]  sel;
        bit          cont;
        int          cnt;
        int          pl;
        int          rdy_pct;
        int          chkr_pct;
        int          run_cyc;
        int          stall_cyc;
        int          exp_beats;
        logic [31:0] exp_first;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not observed as required", name);
    endtask

    // LFSR step from the polynomial exponents 32, 22, 2, 1
    function automatic logic [31:0] prbs_step(input logic [31:0] x);
        return {x[30:0], x[32-1] ^ x[22-1] ^ x[2-1] ^ x[1-1]};
    endfunction

    function automatic logic [DW-1:0] widen(input logic [31:0] w);
        logic [DW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*32 +: 32] = w ^ (32'(i) * 32'h0101_0101);
        return d;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        logic [DW:0]   beat_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW:0]   f;
        logic [31:0]   p;
        logic [31:0]   w;
        logic [31:0]   first_w;
        int plen, total, popped, pushed, first_cyc, cyc;
        bit done_seen;
        p = 32'hFFAA_5555;
        first_w = 32'h0;
        popped = 0; pushed = 0; first_cyc = -1; done_seen = 0;
        plen  = (v.pl == 0) ? 1 : v.pl;
        total = v.cont ? 400 : v.cnt;
        for (int k = 0; k < total; k++) begin
            case (v.sel)
                2'd0:    w = 32'h1111_2222;
                2'd1:    begin w = p; p = prbs_step(p); end
                2'd2:    w = 32'(k);
                default: w = 32'h1 << (k % 32);
            endcase
            beat_q.push_back({(((k + 1) % plen) == 0) || (!v.cont && (k == total - 1)), widen(w)});
            exp_q.push_back(widen(w));
        end
        @(negedge wr_clk);
        patgen_sel = v.sel; cntuspatt_en = v.cont; patgen_cnt = 16'(v.cnt); pkt_len = 8'(v.pl);
        chkr_fifo_full = 1'b0; patgen_en = 1'b1;
        axi.axist_rdy = (v.stall_cyc == 0) && (v.rdy_pct == 100);
        for (cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            if (cyc > 0) begin
                @(negedge wr_clk);
                patgen_sel   = 2'($urandom);
                patgen_cnt   = 16'($urandom);
                pkt_len      = 8'($urandom);
                cntuspatt_en = 1'($urandom);
                axi.axist_rdy  = (cyc >= v.stall_cyc) && ($urandom_range(99) < v.rdy_pct);
                chkr_fifo_full = ($urandom_range(99) < v.chkr_pct);
                if (v.cont && cyc >= v.run_cyc) patgen_en = 1'b0;
            end
            #1;
            if (v.stall_cyc > 0 && cyc == v.stall_cyc) chk("pushes_before_stall_release", pushed, FD);
            if (axi.axist_tvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (beat_q.size() == 0) fail_now("extra_beat");
                else begin
                    f = beat_q[0];
                    chk("tdata", axi.axist_tdata, f[DW-1:0]);
                    chk("tlast", axi.axist_tlast, f[DW]);
                    if (axi.axist_rdy) begin
                        if (popped == 0) first_w = axi.axist_tdata[31:0];
                        void'(beat_q.pop_front());
                        popped++;
                    end
                end
            end
            chk("push_blocked_by_chkr", patgen_exp_valid & chkr_fifo_full, 0);
            if (patgen_exp_valid) begin
                pushed++;
                if (exp_q.size() == 0) fail_now("extra_push");
                else chk("exp_dout", patgen_exp_dout, exp_q.pop_front());
            end else begin
                chk("exp_dout_idle_zero", patgen_exp_dout, 0);
            end
            if (patgen_done) done_seen = 1;
        end
        if (!done_seen) fail_now($sformatf("done_timeout_vec%0d", id));
        if (v.cont) chk("beats_vs_pushes", popped, pushed);
        else        chk($sformatf("beat_count_vec%0d", id), popped, v.exp_beats);
        chk("beat_cnt", beat_cnt, popped);
        chk("busy_at_done", patgen_busy, 0);
        if (popped > 0) chk("first_word", first_w, v.exp_first);
        if (v.rdy_pct == 100 && v.chkr_pct == 0 && v.exp_beats > 0) chk("first_tvalid_latency", first_cyc, 2);
        @(negedge wr_clk);
        patgen_en = 1'b0;
        #1;
        chk("done_one_cycle", patgen_done, 0);
    endtask

    vec_t vecs[7];
    int   pops;
    bit   seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd2, 1'b0,  8,   4, 100,  0,  0,  0,  8, 32'h0000_0000};
        vecs[1] = '{2'd1, 1'b0, 40,   7,  50,  0,  0,  0, 40, 32'hFFAA_5555};
        vecs[2] = '{2'd0, 1'b0,  5,   0,  70, 30,  0,  0,  5, 32'h1111_2222};
        vecs[3] = '{2'd3, 1'b1,  0,   0, 100, 30, 60,  0, -1, 32'h0000_0001};
        vecs[4] = '{2'd1, 1'b0,  0,   3, 100,  0,  0,  0,  0, 32'hFFAA_5555};
        vecs[5] = '{2'd3, 1'b0, 35, 255,  60,  0,  0,  0, 35, 32'h0000_0001};
        vecs[6] = '{2'd2, 1'b0, 20,   5, 100,  0,  0, 12, 20, 32'h0000_0000};

        rst_n = 1'b0; patgen_en = 1'b0; patgen_sel = 2'd0; cntuspatt_en = 1'b0;
        patgen_cnt = 16'd0; pkt_len = 8'd0; chkr_fifo_full = 1'b0; axi.axist_rdy = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        chk("reset_tvalid", axi.axist_tvalid, 0);
        chk("reset_busy", patgen_busy, 0);
        chk("reset_beat_cnt", beat_cnt, 0);
        chk("reset_exp_valid", patgen_exp_valid, 0);
        chk("tkeep", axi.axist_tkeep, {(DW/8){1'b1}});
        rst_n = 1'b1;
        repeat (3) @(negedge wr_clk);
        #1;
        chk("post_reset_quiet", axi.axist_tvalid | patgen_busy | patgen_done, 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a run, then restart from the seed
        @(negedge wr_clk);
        patgen_sel = 2'd2; cntuspatt_en = 1'b0; patgen_cnt = 16'd50; pkt_len = 8'd4;
        axi.axist_rdy = 1'b1; patgen_en = 1'b1;
        pops = 0;
        for (int c = 0; c < 40 && pops < 5; c++) begin
            @(negedge wr_clk);
            #1;
            if (axi.axist_tvalid && axi.axist_rdy) pops++;
        end
        if (pops < 5) fail_now("reset_test_beats");
        @(negedge wr_clk);
        chk("pre_reset_tvalid", axi.axist_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_tvalid", axi.axist_tvalid, 0);
        chk("mid_reset_tlast", axi.axist_tlast, 0);
        chk("mid_reset_tdata", axi.axist_tdata, 0);
        chk("mid_reset_exp_valid", patgen_exp_valid, 0);
        chk("mid_reset_exp_dout", patgen_exp_dout, 0);
        chk("mid_reset_busy", patgen_busy, 0);
        chk("mid_reset_done", patgen_done, 0);
        chk("mid_reset_beat_cnt", beat_cnt, 0);
        @(negedge wr_clk);
        patgen_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge wr_clk);
        #1;
        chk("after_reset_idle", axi.axist_tvalid | patgen_busy, 0);
        run_vec(7, '{2'd2, 1'b0, 6, 3, 100, 0, 0, 0, 6, 32'h0000_0000});

        // Start edge during drain is ignored; no restart without a fresh edge
        @(negedge wr_clk);
        patgen_sel = 2'd0; cntuspatt_en = 1'b0; patgen_cnt = 16'd20; pkt_len = 8'd0;
        axi.axist_rdy = 1'b0; patgen_en = 1'b1;
        repeat (8) @(negedge wr_clk);
        patgen_en = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        chk("drain_busy", patgen_busy, 1);
        chk("drain_tvalid", axi.axist_tvalid, 1);
        @(negedge wr_clk);
        patgen_en = 1'b1;
        repeat (2) @(negedge wr_clk);
        axi.axist_rdy = 1'b1;
        pops = 0; seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            #1;
            if (axi.axist_tvalid) begin
                chk("drain_tdata", axi.axist_tdata, widen(32'h1111_2222));
                chk("drain_tlast", axi.axist_tlast, 1);
                pops++;
            end
            if (patgen_done) seen = 1;
            else @(negedge wr_clk);
        end
        if (!seen) fail_now("drain_done_timeout");
        chk("drain_beats", pops, FD);
        chk("drain_beat_cnt", beat_cnt, FD);
        for (int c = 0; c < 5; c++) begin
            @(negedge wr_clk);
            #1;
            chk("no_restart_without_edge", axi.axist_tvalid | patgen_busy | patgen_exp_valid, 0);
        end
        patgen_en = 1'b0;
        run_vec(8, '{2'd1, 1'b0, 10, 0, 80, 20, 0, 0, 10, 32'hFFAA_5555});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axist_param_patgen.md
AXIST_PARAM_PATGEN -- requirements
Module: axist_param_patgen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, output stream width in bits (multiple of 32, >=32); NUM_LANES = DATA_WIDTH/32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the beat-count input.
REQ-004 SHALL have parameter PRBS_SEED, default 32'hFFAA_5555, LFSR load value; zero is replaced by 32'h1.
REQ-005 SHALL have parameter INCR_SEED, default 32'h0000_0000, incrementing-mode start value.
REQ-006 wr_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 patgen_en  in  1  run enable; a 0->1 transition starts a run.
REQ-009 patgen_sel  in  2  pattern: 00 fixed, 01 PRBS32, 10 incrementing, 11 walking-one.
REQ-010 cntuspatt_en  in  1  1 = continuous mode, 0 = counted mode.
REQ-011 patgen_cnt  in  CNT_WIDTH  beats to generate in counted mode.
REQ-012 pkt_len  in  8  beats per packet; 0 treated as 1.
REQ-013 chkr_fifo_full  in  1  checker backpressure; blocks generation while 1.
REQ-014 axist_tdata  out  DATA_WIDTH  stream data.
REQ-015 axist_tvalid  out  1; axist_tlast  out  1; axist_tkeep  out  DATA_WIDTH/8 (constant all-ones).
REQ-016 axist_rdy  in  1  sink ready.
REQ-017 patgen_exp_dout  out  DATA_WIDTH; patgen_exp_valid  out  1  expected-data copy for checker.
REQ-018 patgen_busy  out  1; patgen_done  out  1 (one-cycle pulse); beat_cnt  out  32  accepted beats.

Function
REQ-019 SHALL implement FSM IDLE/RUN/DRAIN; busy = (state != IDLE).
REQ-020 IDLE: on patgen_en 0->1 SHALL latch patgen_sel, cntuspatt_en, patgen_cnt, pkt_len, load generator seed, clear beat_cnt and packet counter, go RUN.
REQ-021 RUN: push = !fifo_full && !chkr_fifo_full && remaining != 0 (counted) or 1 (continuous); one word per push.
REQ-022 Counted: remaining decrements per push; at remaining==0 SHALL go DRAIN; patgen_cnt==0 -> DRAIN with no push.
REQ-023 patgen_en low in RUN (either mode) SHALL stop pushes and go DRAIN; buffered beats still delivered.
REQ-024 DRAIN: when FIFO empty SHALL pulse patgen_done for one cycle and go IDLE.
REQ-025 Generator word advances only on push: fixed 32'h1111_2222; PRBS32 polynomial x^32+x^22+x^2+x+1, shift left, feedback into bit 0; incr +1 mod 2^32; walking-one from 32'h1, rotate left 1.
REQ-026 Lane i of pushed data SHALL be gen_word XOR (i * 32'h0101_0101); lane 0 at bits [31:0].
REQ-027 tlast stored with data; SHALL be 1 on every pkt_len-th push of the run and on final push of a counted run; packet counter resets after a tlast.
REQ-028 patgen_exp_dout/patgen_exp_valid SHALL equal pushed data and push strobe in the push cycle; exp_dout 0 when not pushing.
REQ-029 FIFO show-ahead: tvalid = !empty; tdata/tlast held stable while tvalid && !axist_rdy; pop on tvalid && axist_rdy.
REQ-030 Push blocked when full even if pop in same cycle; push and pop in same cycle when not full/empty SHALL both occur, occupancy unchanged.
REQ-031 Latency: first tvalid 2 cycles after the cycle in which patgen_en 0->1 is sampled, given no backpressure.
REQ-032 beat_cnt increments on each tvalid && axist_rdy, saturates at 32'hFFFF_FFFF.
REQ-033 Changing sel/cnt/pkt_len during a run SHALL have no effect until the next start.
REQ-034 patgen_en 0->1 while in DRAIN SHALL be ignored; new start requires a fresh 0->1 edge in IDLE.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, FIFO empty, tvalid/tlast/tdata/exp_valid/exp_dout/busy/done = 0, beat_cnt = 0, generator = seed; mid-run reset discards buffered beats.
REQ-036 After rst_n release no output changes until a patgen_en 0->1 edge.

Verification
REQ-037 Counted incr: sel=10, cnt=8, pkt_len=4, rdy=1 -> 8 beats lane0 0..7, tlast on beats 4 and 8, done pulse, beat_cnt=8.
REQ-038 PRBS backpressure: sel=01, cnt=40, rdy toggled randomly -> lane0 matches LFSR from 32'hFFAA_5555, no drop/dup, tdata stable while stalled, exp stream matches.
REQ-039 FIFO full: rdy=0, cnt=20, DATA_WIDTH=64, FIFO_DEPTH=4 -> exactly 4 pushes then stall; rdy=1 -> all 20 delivered in order.
REQ-040 Continuous walking-one, pkt_len=0: chkr_fifo_full pulses stop pushes; patgen_en drop -> drain, done; every beat tlast; lane0 1,2,4,...
REQ-041 Reset mid-run: rst_n low after 5 beats -> all outputs 0 same cycle; restart gives seed-first data, beat_cnt from 0.
REQ-042 Edge cases: cnt=0 -> no tvalid, done pulse; patgen_en re-rise during DRAIN ignored.
